// File: rtl/stack_ctrl_frontend.sv
// stack_ctrl_frontend
//   Command/response front end for a downstream LIFO stack. It accepts one
//   push or pop command at a time and tracks stack occupancy. It issues a
//   single-cycle strobe to the stack and returns one response per command.
//   A push on a full stack or a pop on an empty stack is answered with
//   rsp_err and never reaches the stack.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_op 0=push 1=pop
//   cmd_data                  push payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_err         popped word (0 for push/error), error flag
//   stk_push, stk_pop         one-cycle strobes to the stack
//   stk_wdata, stk_rdata      stack write data / registered read data
//   count, full, empty        occupancy and its decoded bounds
module stack_ctrl_frontend #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [DATA_W-1:0]          stk_wdata,
  input  logic [DATA_W-1:0]          stk_rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_RESP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_is_pop, w_is_pop_nxt;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                r_stk_push, w_stk_push_nxt;
  logic                r_stk_pop, w_stk_pop_nxt;
  logic [DATA_W-1:0]   r_stk_wdata, w_stk_wdata_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                w_full, w_empty;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every output is computed one cycle ahead and registered below, so the
  // strobes and the response appear exactly in the state that owns them.
  always_comb begin
    w_state_nxt     = r_state;
    w_is_pop_nxt    = r_is_pop;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_stk_push_nxt  = 1'b0;
    w_stk_pop_nxt   = 1'b0;
    w_stk_wdata_nxt = '0;
    w_count_nxt     = r_count;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          if ((!cmd_op && w_full) || (cmd_op && w_empty)) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = '0;
          end else begin
            w_state_nxt    = S_ISSUE;
            w_is_pop_nxt   = cmd_op;
            w_stk_push_nxt = !cmd_op;
            w_stk_pop_nxt  = cmd_op;
            if (!cmd_op) begin
              w_stk_wdata_nxt = cmd_data;
            end
          end
        end
      end
      S_ISSUE: begin
        if (r_is_pop) begin
          w_count_nxt = r_count - CNT_W'(1);
          w_state_nxt = S_WAIT_RD;
        end else begin
          w_count_nxt     = r_count + CNT_W'(1);
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_data_nxt  = '0;
        end
      end
      S_WAIT_RD: begin
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_data_nxt  = stk_rdata;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_data_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_pop    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_stk_push  <= 1'b0;
      r_stk_pop   <= 1'b0;
      r_stk_wdata <= '0;
      r_count     <= '0;
    end else begin
      r_is_pop    <= w_is_pop_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_stk_push  <= w_stk_push_nxt;
      r_stk_pop   <= w_stk_pop_nxt;
      r_stk_wdata <= w_stk_wdata_nxt;
      r_count     <= w_count_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign stk_push  = r_stk_push;
  assign stk_pop   = r_stk_pop;
  assign stk_wdata = r_stk_wdata;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule

// File: tb/tb_stack_ctrl_frontend.sv
// tb_stack_ctrl_frontend
//   Directed bench for stack_ctrl_frontend (DATA_W=8, DEPTH=16). A small
//   behavioural stack answers the strobes with registered read data.
module tb_stack_ctrl_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  int n_pop = 0;

  stack_ctrl_frontend #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Downstream stack: shares rst, read data registered on the pop edge.
  logic [7:0] env_mem [16];
  int         env_sp;
  logic [7:0] env_last_wdata;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      env_sp         <= 0;
      stk_rdata      <= '0;
      env_last_wdata <= '0;
    end else if (stk_push && env_sp < 16) begin
      env_mem[4'(env_sp)] <= stk_wdata;
      env_sp              <= env_sp + 1;
      env_last_wdata      <= stk_wdata;
    end else if (stk_pop && env_sp > 0) begin
      stk_rdata <= env_mem[4'(env_sp - 1)];
      env_sp    <= env_sp - 1;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_push += int'(stk_push);
      n_pop  += int'(stk_pop);
      chk(32'(stk_push && stk_pop), 32'd0, "dual_strobe");
    end
  end

  // One full command: handshake, latency, response value, stall stability,
  // completion handshake and strobe count.
  task automatic do_cmd(input logic op, input logic [7:0] d, input int stall,
                        input logic e_err, input logic [7:0] e_data,
                        input int e_lat, input string tag);
    int lat;
    int waitc;
    int e_push;
    int e_pop;
    e_push = (!op && !e_err) ? 1 : 0;
    e_pop  = (op && !e_err) ? 1 : 0;
    @(negedge clk);
    n_push = 0;
    n_pop  = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk(32'(cmd_ready), 32'd1, {tag, "_cmd_ready"});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 1'($urandom);
    cmd_data  = 8'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(32'(lat), 32'(e_lat), {tag, "_latency"});
    chk(32'(rsp_err), 32'(e_err), {tag, "_err"});
    chk(32'(rsp_data), 32'(e_data), {tag, "_data"});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk(32'(rsp_valid), 32'd1, {tag, "_stall_valid"});
      chk(32'(rsp_data), 32'(e_data), {tag, "_stall_data"});
      chk(32'(cmd_ready), 32'd0, {tag, "_stall_cmd_ready"});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk(32'(rsp_valid), 32'd0, {tag, "_rsp_done"});
    chk(32'(cmd_ready), 32'd1, {tag, "_back_idle"});
    chk(32'(n_push), 32'(e_push), {tag, "_push_strobes"});
    chk(32'(n_pop), 32'(e_pop), {tag, "_pop_strobes"});
  endtask

  // Reference stack for the mixed sequence.
  logic [7:0] m_stk [16];
  int         m_cnt = 0;

  task automatic model_cmd(input logic op, input logic [7:0] d, input int stall, input string tag);
    logic       e_err;
    logic [7:0] e_data;
    int         e_lat;
    e_err  = 1'b0;
    e_data = '0;
    if (!op) begin
      if (m_cnt == 16) begin
        e_err = 1'b1;
        e_lat = 1;
      end else begin
        m_stk[4'(m_cnt)] = d;
        m_cnt++;
        e_lat = 2;
      end
    end else begin
      if (m_cnt == 0) begin
        e_err = 1'b1;
        e_lat = 1;
      end else begin
        m_cnt--;
        e_data = m_stk[4'(m_cnt)];
        e_lat  = 3;
      end
    end
    do_cmd(op, d, stall, e_err, e_data, e_lat, tag);
    chk(32'(count), 32'(m_cnt), {tag, "_count"});
  endtask

  logic [19:0] pat;

  initial begin
    // Reset state
    #2;
    chk(32'(count), 32'd0, "rst_count");
    chk(32'(rsp_valid), 32'd0, "rst_rsp_valid");
    chk(32'(rsp_err), 32'd0, "rst_rsp_err");
    chk(32'(rsp_data), 32'd0, "rst_rsp_data");
    chk(32'(stk_push), 32'd0, "rst_stk_push");
    chk(32'(stk_pop), 32'd0, "rst_stk_pop");
    chk(32'(stk_wdata), 32'd0, "rst_stk_wdata");
    chk(32'(empty), 32'd1, "rst_empty");
    chk(32'(full), 32'd0, "rst_full");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(32'(cmd_ready), 32'd1, "rst_cmd_ready");

    // Pop on empty
    do_cmd(1'b1, 8'h00, 0, 1'b1, 8'h00, 1, "pop_empty");
    chk(32'(count), 32'd0, "pop_empty_count");

    // Single push then pop
    do_cmd(1'b0, 8'hA5, 0, 1'b0, 8'h00, 2, "push_a5");
    chk(32'(env_last_wdata), 32'h0A5, "push_a5_wdata");
    chk(32'(count), 32'd1, "push_a5_count");
    do_cmd(1'b1, 8'h00, 0, 1'b0, 8'hA5, 3, "pop_a5");
    chk(32'(count), 32'd0, "pop_a5_count");
    chk(32'(empty), 32'd1, "pop_a5_empty");

    // Fill, overflow, drain in LIFO order
    for (int i = 1; i <= 16; i++) begin
      do_cmd(1'b0, 8'(i), 0, 1'b0, 8'h00, 2, "fill");
    end
    chk(32'(count), 32'd16, "fill_count");
    chk(32'(full), 32'd1, "fill_full");
    do_cmd(1'b0, 8'h77, 0, 1'b1, 8'h00, 1, "push_full");
    chk(32'(count), 32'd16, "push_full_count");
    do_cmd(1'b1, 8'h00, 5, 1'b0, 8'h10, 3, "pop_stall");
    for (int i = 15; i >= 1; i--) begin
      do_cmd(1'b1, 8'h00, 0, 1'b0, 8'(i), 3, "drain");
    end
    chk(32'(count), 32'd0, "drain_count");
    chk(32'(empty), 32'd1, "drain_empty");

    // Mixed push/pop with varying response stalls
    pat = 20'b0110_1111_0100_0111_0100;
    for (int i = 0; i < 20; i++) begin
      model_cmd(pat[i], 8'(i * 7 + 3), i % 3, "mixed");
    end

    // Drain leftovers so the reset test starts from a known level
    while (m_cnt > 0) begin
      model_cmd(1'b1, 8'h00, 0, "mixed_drain");
    end

    // Reset while a pop sits in WAIT_RD
    do_cmd(1'b0, 8'h33, 0, 1'b0, 8'h00, 2, "pre_rst_push");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(32'(rsp_valid), 32'd0, "midrst_rsp_valid");
    chk(32'(count), 32'd0, "midrst_count");
    chk(32'(stk_pop), 32'd0, "midrst_stk_pop");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk(32'(cmd_ready), 32'd1, "midrst_cmd_ready");
    chk(32'(count), 32'd0, "midrst_count_after");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk(32'(rsp_valid), 32'd0, "midrst_no_rsp");
    end

    // Recovery after reset
    do_cmd(1'b0, 8'h5A, 1, 1'b0, 8'h00, 2, "post_rst_push");
    do_cmd(1'b1, 8'h00, 0, 1'b0, 8'h5A, 3, "post_rst_pop");
    chk(32'(count), 32'd0, "post_rst_count");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_ctrl_frontend.md
STACK_CTRL_FRONTEND -- requirements
Module: stack_ctrl_frontend

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stack word width.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries in the downstream stack; power of two, 2..256.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 SHALL have port cmd_ready, output, 1 bit: block accepts a command this cycle.
REQ-007 SHALL have port cmd_op, input, 1 bit: 0 = push, 1 = pop.
REQ-008 SHALL have port cmd_data, input, DATA_W bits: push payload.
REQ-009 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-010 SHALL have port rsp_ready, input, 1 bit: consumer takes the response.
REQ-011 SHALL have port rsp_data, output, DATA_W bits: popped word; 0 for push or error.
REQ-012 SHALL have port rsp_err, output, 1 bit: 1 = push-on-full or pop-on-empty.
REQ-013 SHALL have port stk_push, output, 1 bit: one-cycle push strobe to the stack.
REQ-014 SHALL have port stk_pop, output, 1 bit: one-cycle pop strobe to the stack.
REQ-015 SHALL have port stk_wdata, output, DATA_W bits: data driven with stk_push.
REQ-016 SHALL have port stk_rdata, input, DATA_W bits: stack registered read data, valid the cycle after stk_pop.
REQ-017 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-018 SHALL have ports full and empty, outputs, 1 bit each: count==DEPTH and count==0.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, RESP; all outputs registered except full/empty (decoded from count).
REQ-020 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a rising edge with cmd_valid&&cmd_ready.
REQ-021 Push accepted with count<DEPTH: SHALL enter ISSUE, assert stk_push and stk_wdata=cmd_data for exactly the next cycle, increment count at the end of that cycle, then enter RESP with rsp_err=0, rsp_data=0.
REQ-022 Pop accepted with count>0: SHALL enter ISSUE, assert stk_pop for exactly the next cycle, decrement count at the end of that cycle, enter WAIT_RD for one cycle, capture stk_rdata into rsp_data at its end, then enter RESP with rsp_err=0.
REQ-023 Push with full, or pop with empty: SHALL not strobe the stack, SHALL leave count unchanged, and SHALL enter RESP directly with rsp_err=1, rsp_data=0.
REQ-024 Latency from acceptance edge to first rsp_valid cycle SHALL be: error 1 cycle, push 2 cycles, pop 3 cycles.
REQ-025 In RESP, rsp_valid=1 and rsp_data/rsp_err SHALL hold stable until rsp_valid&&rsp_ready, then return to IDLE; the next command is accepted no earlier than the following cycle.
REQ-026 stk_push and stk_pop SHALL never be high in the same cycle, and each SHALL be high at most one cycle per command.
REQ-027 count SHALL never exceed DEPTH nor drop below 0; the stack is never strobed past its bounds.
REQ-028 cmd_data, cmd_op and stk_rdata SHALL be ignored outside the acceptance edge and the WAIT_RD capture edge respectively.

Reset
REQ-029 On rst high, SHALL immediately enter IDLE, with count=0, cmd_ready=1 once rst is released, and rsp_valid, rsp_err, stk_push, stk_pop=0 and rsp_data, stk_wdata=0.
REQ-030 Reset mid-operation (any state) SHALL abandon the command with no response; the downstream stack shares rst, so occupancy stays consistent.

Verification
REQ-031 Reset, then pop -> no stk_pop; rsp_valid 1 cycle after acceptance with rsp_err=1, rsp_data=0x00; count=0.
REQ-032 Push 0xA5, then pop, rsp_ready=1 -> stk_push one cycle with stk_wdata=0xA5; pop response rsp_data=0xA5, rsp_err=0, 3 cycles after acceptance; count 1 -> 0.
REQ-033 Push 0x01..0x10 (16 pushes) -> full=1, count=16; 17th push -> rsp_err=1, no stk_push; 16 pops return 0x10..0x01 in LIFO order, then empty=1.
REQ-034 Pop response with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data held stable, cmd_ready=0 throughout; single handshake on the cycle rsp_ready rises.
REQ-035 Assert rst during WAIT_RD of a pop -> rsp_valid never rises, count=0, cmd_ready=1 the first cycle after release.
REQ-036 Random push/pop with random rsp_ready stalls against a 16-entry stack model -> no simultaneous strobes, count matches the model, and every response matches the model.
